// File: rtl/mult_div_unit_pkg.sv
// SPECIAL-class funct codes served by the multiply/divide unit, plus a decode helper.
package mult_div_unit_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  function automatic logic is_muldiv(input logic [5:0] funct);
    return (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
           (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Shared iterative datapath: shift-add multiply or restoring divide, one bit per step.
// Result sits in acc after DATA_WIDTH steps; step is only asserted by the owning FSM.
module mdu_iter_core #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    step,
  input  logic                    is_div,
  input  logic [DATA_WIDTH-1:0]   a_mag,
  input  logic [DATA_WIDTH-1:0]   b_mag,
  output logic [2*DATA_WIDTH-1:0] acc,
  output logic                    last
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  logic [W-1:0]   b_reg;
  logic [CW-1:0]  count;
  logic [W:0]     add_sum;
  logic [W:0]     trial;
  logic [2*W-1:0] acc_next;

  // Divide: acc upper half is the partial remainder, lower half shifts dividend out / quotient in.
  always_comb begin
    add_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, b_reg} : '0);
    trial   = acc[2*W-1:W-1] - {1'b0, b_reg};
    if (!is_div)
      acc_next = {add_sum, acc[W-1:1]};
    else if (!trial[W])
      acc_next = {trial[W-1:0], acc[W-2:0], 1'b1};
    else
      acc_next = {acc[2*W-2:0], 1'b0};
  end

  assign last = (count == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      b_reg <= '0;
      count <= '0;
    end else if (load) begin
      acc   <= {{W{1'b0}}, a_mag};
      b_reg <= b_mag;
      count <= CW'(W - 1);
    end else if (step) begin
      acc   <= acc_next;
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU with HI/LO; busy for DATA_WIDTH+1 cycles, then a one-cycle done.
// Requests arriving while busy (including MTHI/MTLO) are dropped; flush aborts without touching HI/LO.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [5:0]            funct,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);
  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP} state_t;

  state_t         state;
  logic           op_div;
  logic           neg_main;
  logic           neg_rem;
  logic           signed_op;
  logic           a_neg;
  logic           b_neg;
  logic           accept;
  logic           load;
  logic           last;
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic [2*W-1:0] acc;

  assign signed_op = ~funct[0];
  assign a_neg     = signed_op & operand_a[W-1];
  assign b_neg     = signed_op & operand_b[W-1];
  assign a_mag     = a_neg ? -operand_a : operand_a;
  assign b_mag     = b_neg ? -operand_b : operand_b;
  assign accept    = (state == S_IDLE) && start && !flush;
  assign load      = accept && is_muldiv(funct);

  mdu_iter_core #(.DATA_WIDTH(W)) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (state == S_CALC),
    .is_div (op_div),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .acc    (acc),
    .last   (last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      op_div   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept && funct == FUNCT_MTHI) hi <= operand_a;
          if (accept && funct == FUNCT_MTLO) lo <= operand_a;
          if (load) begin
            state    <= S_CALC;
            busy     <= 1'b1;
            op_div   <= funct[1];
            neg_main <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
          end
        end
        S_CALC: begin
          if (flush) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (last) begin
            state <= S_FIXUP;
          end
        end
        S_FIXUP: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          if (!flush) begin
            done <= 1'b1;
            if (!op_div) begin
              {hi, lo} <= neg_main ? -acc : acc;
            end else begin
              lo <= neg_main ? -acc[W-1:0]   : acc[W-1:0];
              hi <= neg_rem  ? -acc[2*W-1:W] : acc[2*W-1:W];
            end
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit (DATA_WIDTH=32) with hand-computed expectations.
module tb_mult_div_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  funct = '0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;

  mult_div_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct(funct),
    .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents a request for exactly one cycle; returns at the negedge after the accepting edge.
  task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; funct = f; operand_a = a; operand_b = b;
    @(negedge clk);
    start = 1'b0; funct = 6'h00;
  endtask

  task automatic do_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n = 0;
    issue(f, a, b);
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({tag, " busy_cycles"}, 64'(n), 64'd33);
    check({tag, " done"}, {63'd0, done}, 64'd1);
    check({tag, " hi"}, {32'd0, hi}, {32'd0, exp_hi});
    check({tag, " lo"}, {32'd0, lo}, {32'd0, exp_lo});
    @(negedge clk);
    check({tag, " done_pulse"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int n;
    #12;
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset hi", {32'd0, hi}, 64'd0);
    check("reset lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op("MULT -3*5",  6'h18, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
    do_op("MULTU",      6'h19, 32'hFFFFFFFD, 32'd5, 32'h00000004, 32'hFFFFFFF1);
    do_op("DIVU 100/7", 6'h1B, 32'd100, 32'd7, 32'h00000002, 32'h0000000E);
    do_op("DIV -7/2",   6'h1A, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
    do_op("DIVU 5/0",   6'h1B, 32'd5, 32'd0, 32'h00000005, 32'hFFFFFFFF);
    do_op("DIV MIN/-1", 6'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    do_op("DIV MIN/1",  6'h1A, 32'h80000000, 32'd1, 32'h00000000, 32'h80000000);

    // MTHI in idle
    issue(6'h11, 32'h12345678, 32'd0);
    check("MTHI hi", {32'd0, hi}, 64'h12345678);
    check("MTHI busy", {63'd0, busy}, 64'd0);
    check("MTHI done", {63'd0, done}, 64'd0);

    // MTLO while busy is dropped
    issue(6'h19, 32'd2, 32'd3);
    issue(6'h13, 32'hDEADBEEF, 32'd0);
    check("MTLO busy lo", {32'd0, lo}, 64'h80000000);
    n = 0;
    while (!done && n < 100) begin n++; @(negedge clk); end
    check("MULTU 2*3 lo", {32'd0, lo}, 64'd6);
    check("MULTU 2*3 hi", {32'd0, hi}, 64'd0);

    // Flush in CALC cycle 10
    issue(6'h1A, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", {63'd0, busy}, 64'd0);
    n = 0;
    repeat (40) begin @(negedge clk); if (done) n++; end
    check("flush no done", 64'(n), 64'd0);
    check("flush hi", {32'd0, hi}, 64'd0);
    check("flush lo", {32'd0, lo}, 64'd6);
    do_op("MULT 6*7", 6'h18, 32'd6, 32'd7, 32'd0, 32'd42);

    // Flush and start together in idle: request dropped
    @(negedge clk);
    start = 1'b1; funct = 6'h11; operand_a = 32'hCAFEF00D; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush+MTHI hi", {32'd0, hi}, 64'd0);

    // Async reset mid-CALC
    issue(6'h1B, 32'd1000, 32'd3);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst busy", {63'd0, busy}, 64'd0);
    check("arst done", {63'd0, done}, 64'd0);
    check("arst hi", {32'd0, hi}, 64'd0);
    check("arst lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back: second start issued in the done cycle
    issue(6'h19, 32'd3, 32'd4);
    n = 0;
    while (!done && n < 100) begin n++; @(negedge clk); end
    check("b2b first lo", {32'd0, lo}, 64'd12);
    start = 1'b1; funct = 6'h19; operand_a = 32'd5; operand_b = 32'd5;
    @(negedge clk);
    start = 1'b0; funct = 6'h00;
    check("b2b accepted", {63'd0, busy}, 64'd1);
    n = 1;
    while (!done && n < 100) begin n++; @(negedge clk); end
    check("b2b done gap", 64'(n), 64'd34);
    check("b2b second lo", {32'd0, lo}, 64'd25);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
